// File: rtl/result_serializer.sv
// result_serializer: FIFO-buffered UART-style transmitter for result words.
// Each wr_req pushes one word into a DEPTH-entry FIFO. The transmitter pops
// one word whenever it is idle and sends it LSB first as
// START, DATA_W data bits, [PARITY], STOP. Each bit lasts BAUD_DIV clocks.
// Optional feature: define RESULT_SERIALIZER_PARITY_EN to insert an
// even-parity bit between the last data bit and the stop bit.
// tx_out and tx_busy are registered from the current state, so the line
// trails the FSM by one clock.
module result_serializer #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              tx_busy,
    output logic              tx_out
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int DCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Elaboration-time sanity checks on the parameters.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("result_serializer: DEPTH must be a power of two >= 2");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("result_serializer: BAUD_DIV must be >= 2");
    end
    if (DATA_W < 2) begin : g_bad_width
        $error("result_serializer: DATA_W must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    state_t            state;
    logic              pop;
    logic              push;

    // Pop happens in any IDLE cycle that finds a word waiting; a push is
    // accepted if there is room now or a slot is being freed this cycle.
    assign pop  = (state == IDLE) && !empty;
    assign push = wr_req && (!full || pop);

    // Flags decoded straight from the registered occupancy count.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (wr_req && full && !pop) overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] shreg;
    logic [BCW-1:0]    baud;
    logic [DCW-1:0]    bitn;
    logic              baud_end;
    logic              line;
`ifdef RESULT_SERIALIZER_PARITY_EN
    logic              par;
`endif

    assign baud_end = (baud == BCW'(BAUD_DIV - 1));

    // Line level implied by the current state; registered into tx_out.
    always_comb begin
        line = 1'b1;
        case (state)
            IDLE:    line = 1'b1;
            START:   line = 1'b0;
            DATA:    line = shreg[0];
`ifdef RESULT_SERIALIZER_PARITY_EN
            PARITY:  line = par;
`endif
            STOP:    line = 1'b1;
            default: line = 1'b1;
        endcase
    end

    // Frame FSM: baud timing, bit counting, shifting and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bitn    <= '0;
            shreg   <= '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
            par     <= 1'b0;
`endif
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            tx_out  <= line;
            tx_busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    baud <= '0;
                    if (pop) begin
                        shreg <= mem[rd_ptr];
`ifdef RESULT_SERIALIZER_PARITY_EN
                        par   <= ^mem[rd_ptr];
`endif
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud  <= '0;
                        bitn  <= '0;
                        state <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud  <= '0;
                        shreg <= {1'b0, shreg[DATA_W-1:1]};
                        if (bitn == DCW'(DATA_W - 1)) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitn <= bitn + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef RESULT_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    baud  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: randomized and directed checks of result_serializer
// against a queue-based reference model of the FIFO and the serial line.
// Honours RESULT_SERIALIZER_PARITY_EN when it is defined for the build.
module tb_result_serializer;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 4;
    localparam int BAUD_DIV = 4;
`ifdef RESULT_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (DATA_W + 2 + PAR) * BAUD_DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              full, empty, overflow, tx_busy, tx_out;

    result_serializer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .overflow(overflow),
        .tx_busy (tx_busy),
        .tx_out  (tx_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending words and the line samples still owed
    // for the frame in flight (one entry per clock).
    logic [DATA_W-1:0] m_fifo[$];
    logic              m_line[$];
    int                edge_cnt    = 0;
    int                next_pop_ok = 0;
    logic              m_ovf       = 1'b0;
    logic              exp_tx      = 1'b1;
    logic              exp_busy    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
        end
    endtask

    // Append BAUD_DIV copies of one line level.
    task automatic add_bit(input logic b);
        for (int k = 0; k < BAUD_DIV; k++) m_line.push_back(b);
    endtask

    // Advance the model by one clock edge.
    task automatic model_edge(input logic req, input logic [DATA_W-1:0] data);
        logic              can_pop;
        logic [DATA_W-1:0] w;
        can_pop = (edge_cnt >= next_pop_ok) && (m_fifo.size() > 0);
        if (m_line.size() > 0) begin
            exp_tx   = m_line.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
        if (can_pop) begin
            w = m_fifo.pop_front();
            add_bit(1'b0);
            for (int i = 0; i < DATA_W; i++) add_bit(w[i]);
            if (PAR != 0) add_bit(^w);
            add_bit(1'b1);
            next_pop_ok = edge_cnt + FRAME + 1;
        end
        if (req) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(data);
            else m_ovf = 1'b1;
        end
        edge_cnt++;
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_line.delete();
        m_ovf       = 1'b0;
        next_pop_ok = edge_cnt;
        exp_tx      = 1'b1;
        exp_busy    = 1'b0;
    endtask

    // One clock: drive on the falling edge, model the rising edge, compare 1ns later.
    task automatic cycle(input logic req, input logic [DATA_W-1:0] data);
        @(negedge clk);
        wr_req  = req;
        wr_data = data;
        @(posedge clk);
        model_edge(req, data);
        #1;
        chk("tx_out",   {31'd0, tx_out},   {31'd0, exp_tx});
        chk("tx_busy",  {31'd0, tx_busy},  {31'd0, exp_busy});
        chk("full",     {31'd0, full},     {31'd0, (m_fifo.size() == DEPTH)});
        chk("empty",    {31'd0, empty},    {31'd0, (m_fifo.size() == 0)});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        wr_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk({tag, "_tx_out"},   {31'd0, tx_out},   32'd1);
        chk({tag, "_tx_busy"},  {31'd0, tx_busy},  32'd0);
        chk({tag, "_empty"},    {31'd0, empty},    32'd1);
        chk({tag, "_full"},     {31'd0, full},     32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic rx[0:127];
    int   busy_cnt;
    logic [DATA_W-1:0] rx_word;

    initial begin
        rst     = 1'b1;
        wr_req  = 1'b0;
        wr_data = '0;
        #2;
        chk("rst_tx_out",   {31'd0, tx_out},   32'd1);
        chk("rst_tx_busy",  {31'd0, tx_busy},  32'd0);
        chk("rst_empty",    {31'd0, empty},    32'd1);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word: independent line decode of the frame.
        cycle(1'b1, 16'hA5C3);
        busy_cnt = 0;
        for (int j = 1; j <= FRAME + 5; j++) begin
            cycle(1'b0, '0);
            rx[j]    = tx_out;
            busy_cnt += int'(tx_busy);
        end
        chk("a5c3_idle_e1", {31'd0, rx[1]}, 32'd1);
        chk("a5c3_start_e2", {31'd0, rx[2]}, 32'd0);
        chk("a5c3_start_e5", {31'd0, rx[5]}, 32'd0);
        for (int i = 0; i < DATA_W; i++) rx_word[i] = rx[2 + BAUD_DIV * (1 + i) + 1];
        chk("a5c3_word", {16'd0, rx_word}, 32'h0000A5C3);
        if (PAR != 0) chk("a5c3_parity", {31'd0, rx[2 + BAUD_DIV * (1 + DATA_W) + 1]}, 32'd0);
        chk("a5c3_stop", {31'd0, rx[FRAME + 1]}, 32'd1);
        chk("a5c3_frame_len", busy_cnt, FRAME);

        // Six back-to-back pushes: 6th dropped.
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, DATA_W'(i));
            if (i == 5) chk("burst_full_5th", {31'd0, full}, 32'd1);
        end
        chk("burst_overflow", {31'd0, overflow}, 32'd1);
        idle(5 * (FRAME + 1) + 8);

        // Reset mid-frame with queued words and overflow set.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h1234 + DATA_W'(i));
        idle(20);
        do_reset("midframe");
        idle(4);

        // Fill the FIFO behind a frame, then push exactly on the pop edge.
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0F00 + DATA_W'(i));
        for (int k = 0; k < FRAME + 4; k++)
            cycle(edge_cnt == next_pop_ok, 16'hBEEF);
        chk("push_pop_full", {31'd0, full}, 32'd1);
        chk("push_pop_no_ovf", {31'd0, overflow}, 32'd0);
        idle(5 * (FRAME + 1) + 8);

        // Two queued words; single idle clock between frames checked per cycle.
        cycle(1'b1, 16'h0001);
        cycle(1'b1, 16'h8000);
        idle(2 * (FRAME + 1) + 6);
        chk("two_words_empty", {31'd0, empty}, 32'd1);

        // Randomized traffic with occasional bursts and one reset.
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset("rand_rst");
            if ($urandom_range(0, 199) == 0)
                for (int b = 0; b < int'($urandom_range(2, 7)); b++)
                    cycle(1'b1, DATA_W'($urandom));
            else
                cycle($urandom_range(0, 49) == 0, DATA_W'($urandom));
        end
        idle(DEPTH * (FRAME + 1) + FRAME + 8);
        chk("final_empty", {31'd0, empty}, 32'd1);
        chk("final_idle", {31'd0, tx_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
